decade_seq_ctrl: RTL and testbench

Controller/sequencer for a chain of cascaded BCD decade counter digits. It accepts START/STOP/CLEAR/LOAD commands over a valid/ready handshake and paces counting with an internal prescaler tick. It performs BCD increment with inter-digit carry and flags a terminal match against a compare value. It sits above the decade counter datapath and serves as the single point that sequences and configures it.

---
 rtl/decade_seq_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_decade_seq_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/decade_seq_ctrl.sv
// rtl/decade_seq_ctrl.sv - sequencer for cascaded BCD decade digits; option macro DECADE_SEQ_AUTORELOAD_EN
module decade_seq_ctrl #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [4*DIGITS-1:0] cmd_data,
  input  logic [4*DIGITS-1:0] match_val,
  output logic [4*DIGITS-1:0] count,
  output logic                running,
  output logic                done,
  output logic                bcd_err
);

  localparam int W  = 4 * DIGITS;
  localparam int PW = $clog2(PRESCALE);
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

  localparam logic [1:0] OP_START = 2'b00;
  localparam logic [1:0] OP_STOP  = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;
  localparam logic [1:0] OP_LOAD  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  state_t        state_q, state_nxt;
  logic [PW-1:0] presc_q, presc_nxt;
  logic [W-1:0]  count_q, count_nxt;
  logic          ready_q, ready_nxt;
  logic          done_q, done_nxt;
  logic          err_q, err_nxt;
  logic          accept;
  logic          tick;
  logic          tick_go;
  logic [W-1:0]  count_inc;
  logic          load_ok;
  logic          match_ok;

`ifdef DECADE_SEQ_AUTORELOAD_EN
  logic [W-1:0]  reload_q, reload_nxt;
`endif

  // True when every nibble is a legal BCD digit.
  function automatic logic bcd_valid(input logic [W-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  // Ripple BCD increment; a digit advances only while every lower digit rolled over.
  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign accept    = cmd_valid && ready_q;
  assign tick      = (state_q == ST_RUN) && (presc_q == PS_LAST);
  assign count_inc = bcd_inc(count_q);
  assign load_ok   = bcd_valid(cmd_data);
  assign match_ok  = bcd_valid(match_val) && (count_inc == match_val);

  // Next-state: commands first, then a tick only if no command claimed this edge.
  always_comb begin
    state_nxt = state_q;
    presc_nxt = presc_q;
    count_nxt = count_q;
    err_nxt   = err_q;
    done_nxt  = 1'b0;
    ready_nxt = !accept;
    tick_go   = tick;
`ifdef DECADE_SEQ_AUTORELOAD_EN
    reload_nxt = reload_q;
`endif

    if (state_q == ST_RUN) begin
      presc_nxt = tick ? '0 : presc_q + PW'(1);
    end

    if (accept) begin
      case (cmd_op)
        OP_START: begin
          if (state_q != ST_RUN) begin
            state_nxt = ST_RUN;
            presc_nxt = '0;
          end
        end
        OP_STOP: begin
          if (state_q == ST_RUN) begin
            state_nxt = ST_IDLE;
            presc_nxt = '0;
            tick_go   = 1'b0;
          end
        end
        OP_CLEAR: begin
          count_nxt = '0;
          presc_nxt = '0;
          err_nxt   = 1'b0;
          tick_go   = 1'b0;
          if (state_q == ST_DONE) state_nxt = ST_IDLE;
        end
        default: begin
          if (load_ok) begin
            count_nxt = cmd_data;
            presc_nxt = '0;
`ifdef DECADE_SEQ_AUTORELOAD_EN
            reload_nxt = cmd_data;
`endif
          end else begin
            err_nxt = 1'b1;
          end
          tick_go = 1'b0;
          if (state_q == ST_DONE) state_nxt = ST_IDLE;
        end
      endcase
    end

    if (tick_go) begin
      if (match_ok) begin
        done_nxt = 1'b1;
`ifdef DECADE_SEQ_AUTORELOAD_EN
        count_nxt = reload_q;
`else
        count_nxt = count_inc;
        state_nxt = ST_DONE;
`endif
      end else begin
        count_nxt = count_inc;
      end
    end
  end

  // State register with synchronous reset taking priority over commands and ticks.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      presc_q <= '0;
      count_q <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef DECADE_SEQ_AUTORELOAD_EN
      reload_q <= '0;
`endif
    end else begin
      state_q <= state_nxt;
      presc_q <= presc_nxt;
      count_q <= count_nxt;
      ready_q <= ready_nxt;
      done_q  <= done_nxt;
      err_q   <= err_nxt;
`ifdef DECADE_SEQ_AUTORELOAD_EN
      reload_q <= reload_nxt;
`endif
    end
  end

  assign cmd_ready = ready_q;
  assign count     = count_q;
  assign running   = (state_q == ST_RUN);
  assign done      = done_q;
  assign bcd_err   = err_q;

endmodule

// File: tb/tb_decade_seq_ctrl.sv
// tb/tb_decade_seq_ctrl.sv - directed and random checks of decade_seq_ctrl against a decimal model
module tb_decade_seq_ctrl;

  localparam int DIGITS   = 2;
  localparam int PRESCALE = 3;
  localparam int W        = 4 * DIGITS;
  localparam int MOD      = 10 ** DIGITS;

  localparam logic [1:0] OP_START = 2'b00;
  localparam logic [1:0] OP_STOP  = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;
  localparam logic [1:0] OP_LOAD  = 2'b11;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [1:0]   cmd_op = 2'b00;
  logic [W-1:0] cmd_data = '0;
  logic [W-1:0] match_val = '0;
  logic [W-1:0] count;
  logic         running;
  logic         done;
  logic         bcd_err;

  int checks = 0;
  int errors = 0;

  // model: count held as a decimal integer, time as cycles since last tick/start
  int m_cnt    = 0;
  int m_phase  = 0;
  bit m_run    = 0;
  bit m_done   = 0;
  bit m_ready  = 1;
  bit m_err    = 0;
  int m_reload = 0;

  decade_seq_ctrl #(.DIGITS(DIGITS), .PRESCALE(PRESCALE)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .match_val (match_val),
    .count     (count),
    .running   (running),
    .done      (done),
    .bcd_err   (bcd_err)
  );

  always #5 clk = ~clk;

  function automatic bit bcd_ok(input logic [W-1:0] b);
    bit ok = 1;
    for (int i = 0; i < DIGITS; i++) if (b[4*i +: 4] > 4'd9) ok = 0;
    return ok;
  endfunction

  function automatic int bcd2int(input logic [W-1:0] b);
    int n = 0;
    for (int i = DIGITS - 1; i >= 0; i--) n = n * 10 + int'(b[4*i +: 4]);
    return n;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int n);
    logic [W-1:0] b;
    int t = n;
    for (int i = 0; i < DIGITS; i++) begin
      b[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return b;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_update(input logic r, input logic v, input logic [1:0] op, input logic [W-1:0] d);
    bit acc, tick, kill, nd;
    int nphase, nc;
    if (r) begin
      m_cnt = 0; m_phase = 0; m_run = 0; m_done = 0; m_ready = 1; m_err = 0; m_reload = 0;
    end else begin
      acc    = v && m_ready;
      tick   = m_run && (m_phase == PRESCALE - 1);
      nphase = m_run ? (tick ? 0 : m_phase + 1) : m_phase;
      kill   = 0;
      nd     = 0;
      if (acc) begin
        case (op)
          OP_START: if (!m_run) begin m_run = 1; nphase = 0; end
          OP_STOP:  if (m_run) begin m_run = 0; nphase = 0; kill = 1; end
          OP_CLEAR: begin m_cnt = 0; nphase = 0; m_err = 0; kill = 1; end
          default: begin
            if (bcd_ok(d)) begin
              m_cnt = bcd2int(d); nphase = 0; m_reload = bcd2int(d);
            end else begin
              m_err = 1;
            end
            kill = 1;
          end
        endcase
      end
      if (tick && !kill) begin
        nc = (m_cnt + 1) % MOD;
        if (bcd_ok(match_val) && nc == bcd2int(match_val)) begin
          nd = 1;
`ifdef DECADE_SEQ_AUTORELOAD_EN
          m_cnt = m_reload;
`else
          m_cnt = nc;
          m_run = 0;
`endif
        end else begin
          m_cnt = nc;
        end
      end
      m_phase = nphase;
      m_done  = nd;
      m_ready = !acc;
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [1:0] op, input logic [W-1:0] d);
    rst = r; cmd_valid = v; cmd_op = op; cmd_data = d;
    @(posedge clk);
    model_update(r, v, op, d);
    @(negedge clk);
    check("count",     32'(count),     32'(int2bcd(m_cnt)));
    check("running",   32'(running),   32'(m_run));
    check("done",      32'(done),      32'(m_done));
    check("cmd_ready", 32'(cmd_ready), 32'(m_ready));
    check("bcd_err",   32'(bcd_err),   32'(m_err));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, OP_START, '0);
  endtask

  initial begin
    logic [W-1:0] d;
    logic [1:0]   op;

    // reset with a LOAD pending: dropped
    step(1'b1, 1'b1, OP_LOAD, 8'h55);
    step(1'b1, 1'b1, OP_LOAD, 8'h55);
    idle(1);

    // LOAD 07, count up to match 12, then stop in DONE
    match_val = 8'h12;
    step(1'b0, 1'b1, OP_LOAD, 8'h07);
    idle(1);
    step(1'b0, 1'b1, OP_START, '0);
    idle(20);

    // 99 wraps to 00 with no done
    match_val = 8'h05;
    step(1'b0, 1'b1, OP_LOAD, 8'h99);
    idle(1);
    step(1'b0, 1'b1, OP_START, '0);
    idle(4);
    step(1'b0, 1'b1, OP_STOP, '0);
    idle(1);

    // invalid LOAD sets bcd_err, CLEAR removes it
    step(1'b0, 1'b1, OP_LOAD, 8'h3A);
    idle(1);
    step(1'b0, 1'b1, OP_CLEAR, '0);
    idle(1);

    // STOP lands on a tick edge; restart timing
    match_val = 8'h99;
    step(1'b0, 1'b1, OP_START, '0);
    for (int k = 0; k < 8 && !(m_run && m_phase == PRESCALE - 1); k++) idle(1);
    step(1'b0, 1'b1, OP_STOP, '0);
    idle(2);
    step(1'b0, 1'b1, OP_START, '0);
    idle(7);
    step(1'b0, 1'b1, OP_STOP, '0);
    idle(1);

    // match at 12 from 10 (reloads when the option is built in)
    match_val = 8'h12;
    step(1'b0, 1'b1, OP_LOAD, 8'h10);
    idle(1);
    step(1'b0, 1'b1, OP_START, '0);
    idle(20);

    // random traffic
    for (int n = 0; n < 800; n++) begin
      if ($urandom % 10 == 0) begin
        if ($urandom % 6 == 0) match_val = W'($urandom);
        else match_val = int2bcd((m_cnt + int'($urandom % 4)) % MOD);
      end
      op = 2'($urandom);
      if ($urandom % 6 == 0) d = W'($urandom);
      else d = int2bcd(int'($urandom % MOD));
      step(($urandom % 120) == 0, ($urandom % 3) == 0, op, d);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
